// File: rtl/sound_pkg.sv
// Shared types and default constants for the collision-sound request path.
//  snd_evt_t   : kind of queued event (good / bad collision)
//  seq_state_t : request sequencer states
//  DEF_*       : default tone divisors, durations and silence gap
package sound_pkg;

    typedef enum logic {EVT_GOOD, EVT_BAD} snd_evt_t;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_PLAY, S_GAP} seq_state_t;

    localparam logic [7:0]  DEF_GOOD_FREQ = 8'd107;        // 440 Hz @ 12 MHz
    localparam logic [7:0]  DEF_BAD_FREQ  = 8'd188;        // 250 Hz @ 12 MHz
    localparam logic [23:0] DEF_GOOD_DUR  = 24'd3000000;
    localparam logic [23:0] DEF_BAD_DUR   = 24'd10000000;
    localparam int unsigned DEF_GAP       = 12000;
    localparam int unsigned DEF_ACK_TO    = 16;

endpackage

// File: rtl/sound_req_sequencer_if.sv
// Tone command handshake between the sequencer (master) and the
// oscillator/DAC tone path (slave).
//  tone_req  : master -> slave, request held until busy or timeout
//  tone_freq : master -> slave, divisor, stable while tone_req=1
//  tone_dur  : master -> slave, duration in clk cycles
//  tone_busy : slave -> master, tone path is playing
interface sound_req_sequencer_if;

    logic        tone_req;
    logic [7:0]  tone_freq;
    logic [23:0] tone_dur;
    logic        tone_busy;

    modport master (output tone_req, output tone_freq, output tone_dur, input tone_busy);
    modport slave  (input tone_req, input tone_freq, input tone_dur, output tone_busy);

endinterface

// File: rtl/sound_evt_fifo.sv
// Small event FIFO with registered read data.
//  clk, nRst  : clock, async active-low reset
//  push       : write push_data (accepted when not full, or when popping)
//  push_data  : event to store
//  pop        : remove head; head appears on pop_data the following cycle
//  pop_data   : registered head value captured by the last pop
//  accept     : this cycle's push is being stored
//  full/empty : occupancy flags
module sound_evt_fifo
    import sound_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic     clk,
    input  logic     nRst,
    input  logic     push,
    input  snd_evt_t push_data,
    input  logic     pop,
    output snd_evt_t pop_data,
    output logic     accept,
    output logic     full,
    output logic     empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    snd_evt_t        mem [DEPTH];
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [AW:0]     count_q;
    snd_evt_t        pop_data_q;
    logic            pop_ok;

    assign full     = (count_q == FULL_CNT);
    assign empty    = (count_q == '0);
    assign pop_ok   = pop & ~empty;
    // When full, a simultaneous pop frees the slot being written; the read
    // below still returns the old head because both use non-blocking updates.
    assign accept   = push & (~full | pop_ok);
    assign pop_data = pop_data_q;

    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            pop_data_q <= EVT_GOOD;
        end else begin
            if (accept) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;   // power-of-two depth wraps naturally
            end
            if (pop_ok) begin
                rd_ptr_q   <= rd_ptr_q + 1'b1;
                pop_data_q <= mem[rd_ptr_q];
            end
            case ({accept, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/sound_req_sequencer.sv
// Collects good/bad collision pulses into a FIFO and issues them one at a
// time as tone commands over a req/busy handshake, with a silence gap after
// every tone.
//  clk, nRst          : clock, async active-low reset
//  goodColl, badColl  : single-cycle event pulses (bad wins if both)
//  tone               : tone command handshake (master side)
//  queue_full         : FIFO holds DEPTH entries
//  drop_cnt           : saturating count of discarded events
//  ack_err            : sticky, a request was never acknowledged
module sound_req_sequencer
    import sound_pkg::*;
#(
    parameter int unsigned DEPTH     = 4,
    parameter logic [7:0]  GOOD_FREQ = DEF_GOOD_FREQ,
    parameter logic [7:0]  BAD_FREQ  = DEF_BAD_FREQ,
    parameter logic [23:0] GOOD_DUR  = DEF_GOOD_DUR,
    parameter logic [23:0] BAD_DUR   = DEF_BAD_DUR,
    parameter int unsigned GAP       = DEF_GAP,
    parameter int unsigned ACK_TO    = DEF_ACK_TO
) (
    input  logic                    clk,
    input  logic                    nRst,
    input  logic                    goodColl,
    input  logic                    badColl,
    sound_req_sequencer_if.master   tone,
    output logic                    queue_full,
    output logic [7:0]              drop_cnt,
    output logic                    ack_err
);

    localparam int unsigned ACK_W = $clog2(ACK_TO + 1);
    localparam logic [ACK_W-1:0] ACK_LAST = ACK_W'(ACK_TO - 1);
    localparam logic [15:0]      GAP_LAST = 16'(GAP - 1);

    seq_state_t       state_q;
    logic             pop_pend_q;
    logic [ACK_W-1:0] ack_cnt_q;
    logic [15:0]      gap_cnt_q;
    logic             tone_req_q;
    logic [7:0]       freq_q;
    logic [23:0]      dur_q;
    logic             ack_err_q;
    logic [7:0]       drop_q;
    logic [7:0]       drop_d;

    logic             push_req;
    logic             fifo_pop;
    logic             fifo_accept;
    logic             fifo_full;
    logic             fifo_empty;
    snd_evt_t         push_evt;
    snd_evt_t         head_evt;
    logic [1:0]       drop_inc;
    logic [8:0]       drop_sum;

    assign push_req = goodColl | badColl;
    assign push_evt = badColl ? EVT_BAD : EVT_GOOD;
    // Pop in IDLE, then spend one more IDLE cycle waiting for the registered
    // FIFO read before loading the command.
    assign fifo_pop = (state_q == S_IDLE) & ~pop_pend_q & ~fifo_empty;

    sound_evt_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .nRst      (nRst),
        .push      (push_req),
        .push_data (push_evt),
        .pop       (fifo_pop),
        .pop_data  (head_evt),
        .accept    (fifo_accept),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // A simultaneous good+bad loses the good event; a rejected push loses
    // whatever was offered. Both can happen in one cycle.
    always_comb begin
        drop_inc = {1'b0, goodColl & badColl} + {1'b0, push_req & ~fifo_accept};
        drop_sum = 9'(drop_q) + 9'(drop_inc);
        drop_d   = drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            drop_q <= '0;
        end else begin
            drop_q <= drop_d;
        end
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q    <= S_IDLE;
            pop_pend_q <= 1'b0;
            ack_cnt_q  <= '0;
            gap_cnt_q  <= '0;
            tone_req_q <= 1'b0;
            freq_q     <= '0;
            dur_q      <= '0;
            ack_err_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (pop_pend_q) begin
                        pop_pend_q <= 1'b0;
                        tone_req_q <= 1'b1;
                        ack_cnt_q  <= '0;
                        freq_q     <= (head_evt == EVT_BAD) ? BAD_FREQ : GOOD_FREQ;
                        dur_q      <= (head_evt == EVT_BAD) ? BAD_DUR  : GOOD_DUR;
                        state_q    <= S_REQ;
                    end else if (!fifo_empty) begin
                        pop_pend_q <= 1'b1;
                    end
                end
                S_REQ: begin
                    if (tone.tone_busy) begin
                        tone_req_q <= 1'b0;
                        state_q    <= S_PLAY;
                    end else if (ack_cnt_q == ACK_LAST) begin
                        tone_req_q <= 1'b0;
                        ack_err_q  <= 1'b1;
                        gap_cnt_q  <= '0;
                        state_q    <= S_GAP;
                    end else begin
                        ack_cnt_q <= ack_cnt_q + 1'b1;
                    end
                end
                S_PLAY: begin
                    if (!tone.tone_busy) begin
                        gap_cnt_q <= '0;
                        state_q   <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (gap_cnt_q == GAP_LAST) begin
                        state_q <= S_IDLE;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign tone.tone_req  = tone_req_q;
    assign tone.tone_freq = freq_q;
    assign tone.tone_dur  = dur_q;
    assign queue_full     = fifo_full;
    assign drop_cnt       = drop_q;
    assign ack_err        = ack_err_q;

endmodule
